// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID queue constants: word width, NOP encoding, default depth and entry layout.
package if_id_queue_pkg;

   localparam int unsigned IF_ID_WORD_W        = 32;
   localparam int unsigned IF_ID_DEPTH_DEFAULT = 2;
   localparam logic [IF_ID_WORD_W-1:0] IF_ID_NOP = 32'h0000_0000;

   typedef struct packed {
      logic [IF_ID_WORD_W-1:0] instr;
      logic [IF_ID_WORD_W-1:0] pc_plus4;
   } if_id_entry_t;

endpackage

// File: rtl/if_id_store.sv
// IF/ID queue storage array: one synchronous write port, one asynchronous read port.
module if_id_store
   import if_id_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IF_ID_DEPTH_DEFAULT,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  if_id_entry_t  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output if_id_entry_t  rdata_o
);

   // Payload only; occupancy lives in the queue, so no reset is needed here.
   if_id_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue with flush. Define IF_ID_DELAY_SLOT_EN to keep the
// first surviving instruction on flush (branch delay slot).
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IF_ID_DEPTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IF_ID_WORD_W-1:0] Instruction_F,
   input  logic [IF_ID_WORD_W-1:0] PcPlus4_F,
   input  logic                    valid_F,
   output logic                    ready_F,
   output logic [IF_ID_WORD_W-1:0] Instruction_D,
   output logic [IF_ID_WORD_W-1:0] PcPlus4_D,
   output logic                    valid_D,
   input  logic                    ready_D,
   input  logic                    flush,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   if_id_entry_t  wdata, rdata;

   assign ready_F = (count_q != CW'(DEPTH));
   assign valid_D = (count_q != '0);
   assign push    = valid_F & ready_F;
   assign pop     = valid_D & ready_D;
   assign wdata   = '{instr: Instruction_F, pc_plus4: PcPlus4_F};

   // A push always lands in a free slot, so writing it even when a flush
   // discards it cannot disturb a surviving entry.
   if_id_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
`ifdef IF_ID_DELAY_SLOT_EN
         // Survivor is re-framed as a one-entry queue by moving the pointers around it.
         if (pop && (count_q > CW'(1))) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            wr_ptr_d = rd_ptr_q + AW'(2);
            count_d  = CW'(1);
         end else if (!pop && valid_D) begin
            wr_ptr_d = rd_ptr_q + AW'(1);
            count_d  = CW'(1);
         end else if (push) begin
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = CW'(1);
         end else begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
         end
`else
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
`endif
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign Instruction_D = valid_D ? rdata.instr    : IF_ID_NOP;
   assign PcPlus4_D     = valid_D ? rdata.pc_plus4 : '0;
   assign count         = count_q;

endmodule
